servo_cmd_scheduler: RTL

- Sequences configuration of the servo PWM datapath.
- Parses the SPI byte stream into framed 3-byte commands: index, value high byte, value low byte.
- Range-checks each command and holds accepted values in shadow registers.
- Commits pulse and period values to the PWM generators only at period boundaries, so no PWM cycle ever sees a mid-period change.
- Replaces ad-hoc byte counting with a timeout- and select-resynchronised parser that reports errors.

---
 rtl/servo_cmd_scheduler_pkg.sv | 22 ++
 rtl/servo_cmd_scheduler_if.sv | 27 ++
 rtl/servo_cmd_scheduler_parser.sv | 80 ++++++++
 rtl/servo_cmd_scheduler.sv | 103 ++++++++++
 4 files changed

// File: rtl/servo_cmd_scheduler_pkg.sv
// Purpose: shared constants, defaults and parser state encoding for the servo command scheduler.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package servo_pkg;

  // Frame index that addresses the PWM period instead of a pulse channel
  localparam logic [7:0] CMD_PERIOD = 8'hFF;

  // Defaults in microsecond ticks
  localparam int PULSE_MIN      = 500;
  localparam int PULSE_MAX      = 2500;
  localparam int PULSE_DEFAULT  = 1500;
  localparam int PERIOD_DEFAULT = 20000;

  // Parser position within a 3-byte frame: index, value high, value low
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

endpackage

// File: rtl/servo_cmd_scheduler_if.sv
// Purpose: byte stream, period strobe and committed PWM configuration between host logic and scheduler.
// Latency: wires only.
// Backpressure: none; bytes are strobes and must be taken when offered.
interface servo_cmd_if #(
  parameter int NUM_CHANNELS = 2
);
  logic                        i_byte_valid;
  logic [7:0]                  i_byte;
  logic                        i_select;
  logic                        i_period_start;
  logic [16*NUM_CHANNELS-1:0]  o_pulse;
  logic [15:0]                 o_period;
  logic [NUM_CHANNELS:0]       o_pending;
  logic                        o_cmd_ok;
  logic                        o_cmd_err;
  logic [7:0]                  o_err_count;

  modport master (
    output i_byte_valid, i_byte, i_select, i_period_start,
    input  o_pulse, o_period, o_pending, o_cmd_ok, o_cmd_err, o_err_count
  );

  modport slave (
    input  i_byte_valid, i_byte, i_select, i_period_start,
    output o_pulse, o_period, o_pending, o_cmd_ok, o_cmd_err, o_err_count
  );
endinterface

// File: rtl/servo_cmd_scheduler_parser.sv
// Purpose: frames the byte stream into index/value commands, resyncing on timeout or slave-select release.
// Latency: frame and abort strobes are combinational in the cycle the last byte / abort condition occurs.
// Backpressure: none; a byte with select high is dropped, a stalled frame is aborted after TIMEOUT_CYCLES.
module servo_frame_parser
  import servo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_select,
  output logic        frame_vld,
  output logic [7:0]  frame_idx,
  output logic [15:0] frame_val,
  output logic        abort_vld
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_take;

  assign byte_take = i_byte_valid & ~i_select;

  // Parser state, latched frame bytes and inter-byte timeout counter
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hi_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state: advance on consumed bytes; abort a partial frame on select release or timeout
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    tmo_d     = '0;
    frame_vld = 1'b0;
    abort_vld = 1'b0;
    frame_idx = idx_q;
    frame_val = {hi_q, i_byte};
    case (state_q)
      ST_IDLE: begin
        if (byte_take) begin
          idx_d   = i_byte;
          state_d = ST_HI;
        end
      end
      ST_HI, ST_LO: begin
        if (byte_take) begin
          if (state_q == ST_HI) begin
            hi_d    = i_byte;
            state_d = ST_LO;
          end else begin
            frame_vld = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (i_select || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          abort_vld = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/servo_cmd_scheduler.sv
// Purpose: validates parsed commands into shadow registers and commits them to PWM outputs at period rollover.
// Latency: ok/err/shadow/pending one cycle after the final byte; commit one cycle after i_period_start.
// Backpressure: none; illegal or aborted frames are dropped and counted (saturating).
module servo_cmd_scheduler #(
  parameter int NUM_CHANNELS   = 2,
  parameter int PULSE_MIN      = servo_pkg::PULSE_MIN,
  parameter int PULSE_MAX      = servo_pkg::PULSE_MAX,
  parameter int PULSE_DEFAULT  = servo_pkg::PULSE_DEFAULT,
  parameter int PERIOD_DEFAULT = servo_pkg::PERIOD_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input logic        i_clock,
  input logic        i_reset,
  servo_cmd_if.slave bus
);
  logic                         frame_vld;
  logic [7:0]                   frame_idx;
  logic [15:0]                  frame_val;
  logic                         abort_vld;
  logic                         frame_legal;
  logic                         write_ok;
  logic                         err_d;
  logic [NUM_CHANNELS:0]        pending_q, pending_d;
  logic [NUM_CHANNELS-1:0][15:0] pulse_q, shadow_q;
  logic [15:0]                  period_q, shadow_per_q;
  logic                         ok_q, err_q;
  logic [7:0]                   err_cnt_q;

  servo_frame_parser #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_parser (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_byte_valid (bus.i_byte_valid),
    .i_byte       (bus.i_byte),
    .i_select     (bus.i_select),
    .frame_vld    (frame_vld),
    .frame_idx    (frame_idx),
    .frame_val    (frame_val),
    .abort_vld    (abort_vld)
  );

  // Range check: channel pulses within [min,max], period strictly above the max pulse
  always_comb begin
    frame_legal = 1'b0;
    if (int'(frame_idx) < NUM_CHANNELS)
      frame_legal = (int'(frame_val) >= PULSE_MIN) && (int'(frame_val) <= PULSE_MAX);
    else if (frame_idx == servo_pkg::CMD_PERIOD)
      frame_legal = int'(frame_val) > PULSE_MAX;
  end

  assign write_ok = frame_vld & frame_legal;
  assign err_d    = (frame_vld & ~frame_legal) | abort_vld;

  // Pending flags: a commit clears everything it copies; a same-cycle write re-arms its own bit
  always_comb begin
    pending_d = bus.i_period_start ? '0 : pending_q;
    if (write_ok) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (int'(frame_idx) == c) pending_d[c] = 1'b1;
      if (frame_idx == servo_pkg::CMD_PERIOD) pending_d[NUM_CHANNELS] = 1'b1;
    end
  end

  // Shadows, committed outputs, status pulses and saturating error counter
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        pulse_q[c]  <= 16'(PULSE_DEFAULT);
        shadow_q[c] <= 16'(PULSE_DEFAULT);
      end
      period_q     <= 16'(PERIOD_DEFAULT);
      shadow_per_q <= 16'(PERIOD_DEFAULT);
      pending_q    <= '0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      // Commit reads the shadow as it stood before any same-cycle write
      if (bus.i_period_start) begin
        for (int c = 0; c < NUM_CHANNELS; c++)
          if (pending_q[c]) pulse_q[c] <= shadow_q[c];
        if (pending_q[NUM_CHANNELS]) period_q <= shadow_per_q;
      end
      if (write_ok) begin
        for (int c = 0; c < NUM_CHANNELS; c++)
          if (int'(frame_idx) == c) shadow_q[c] <= frame_val;
        if (frame_idx == servo_pkg::CMD_PERIOD) shadow_per_q <= frame_val;
      end
      pending_q <= pending_d;
      ok_q      <= write_ok;
      err_q     <= err_d;
      if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.o_pulse     = pulse_q;
  assign bus.o_period    = period_q;
  assign bus.o_pending   = pending_q;
  assign bus.o_cmd_ok    = ok_q;
  assign bus.o_cmd_err   = err_q;
  assign bus.o_err_count = err_cnt_q;
endmodule
